// File: rtl/copy_cmd_queue_pkg.sv
// Shared copier definitions: dispatch FSM states, queued command layout and
// completion record field offsets.
package copy_cmd_queue_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_S,
        LD_D,
        LD_L,
        WAIT_START,
        WAIT_DONE,
        CAPTURE
    } copyState_t;

    typedef struct packed {
        logic [30:0] src;
        logic [30:0] dst;
        logic [30:0] len;
    } copyCmd_t;

    localparam int unsigned CMD_WIDTH      = $bits(copyCmd_t);
    localparam int unsigned DONE_REC_WIDTH = 24;
    localparam int unsigned DONE_CKS_LSB   = 0;
    localparam int unsigned DONE_SEQ_LSB   = 16;

endpackage

// File: rtl/sync_fifo.sv
// Flop-based synchronous FIFO with occupancy count; pushes when full and pops
// when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == CNT_FULL);
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdData = mem[rdPtr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_ONE;
            if (doPop)  rdPtr <= rdPtr + PTR_ONE;
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/copy_cmd_queue.sv
// Queues {source, destination, length} copy commands from the RISC write queue,
// feeds them to the copier one at a time and collects checksummed completions.
module copy_cmd_queue
    import copy_cmd_queue_pkg::*;
#(
    parameter int unsigned CMD_DEPTH  = 4,
    parameter int unsigned DONE_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] wq,
    input  logic        cmdWrS,
    input  logic        cmdWrD,
    input  logic        cmdWrL,
    output logic [4:0]  cmdCount,
    output logic        cmdFull,
    output logic        loadS,
    output logic        loadD,
    output logic        loadL,
    output logic [31:0] cpyData,
    input  logic [16:0] chkBusy,
    output logic        doneValid,
    output logic [31:0] doneData,
    input  logic        doneRead,
    output logic        busy,
    output logic        lostCmd
);

    localparam int unsigned CMD_CW  = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned DONE_CW = $clog2(DONE_DEPTH) + 1;

    copyState_t                      state;
    copyState_t                      stateNext;
    logic [30:0]                     stageS;
    logic [30:0]                     stageD;
    copyCmd_t                        pushCmd;
    copyCmd_t                        headCmd;
    copyCmd_t                        curCmd;
    logic [CMD_CW-1:0]               cmdCnt;
    logic                            cmdEmpty;
    logic                            dispatch;
    logic                            capture;
    logic                            startWaited;
    logic [7:0]                      seq;
    logic [DONE_REC_WIDTH-1:0]       doneRec;
    logic [DONE_REC_WIDTH-1:0]       doneHead;
    logic                            doneFull;
    logic                            doneEmpty;
    logic [DONE_CW-1:0]              unusedDoneCount;
    logic                            unusedWq;

    assign unusedWq = wq[31];

    always_ff @(posedge clock) begin
        if (!reset) begin
            stageS  <= '0;
            stageD  <= '0;
            lostCmd <= 1'b0;
        end else begin
            if (cmdWrS) stageS <= wq[30:0];
            if (cmdWrD) stageD <= wq[30:0];
            if (cmdWrL && cmdFull) lostCmd <= 1'b1;
        end
    end

    // The length comes straight from wq so the command is complete on the L strobe.
    assign pushCmd = '{src: stageS, dst: stageD, len: wq[30:0]};

    sync_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (CMD_DEPTH)
    ) cmdFifo (
        .clock  (clock),
        .reset  (reset),
        .push   (cmdWrL),
        .wrData (pushCmd),
        .pop    (dispatch),
        .rdData (headCmd),
        .count  (cmdCnt),
        .full   (cmdFull),
        .empty  (cmdEmpty)
    );

    assign cmdCount = 5'(cmdCnt);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            curCmd      <= '0;
            seq         <= '0;
            startWaited <= 1'b0;
        end else begin
            state       <= stateNext;
            startWaited <= (state == WAIT_START);
            if (dispatch) curCmd <= headCmd;
            if (capture)  seq <= seq + 8'd1;
        end
    end

    always_comb begin
        stateNext = state;
        loadS     = 1'b0;
        loadD     = 1'b0;
        loadL     = 1'b0;
        cpyData   = '0;
        dispatch  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                // Holding back while the completion FIFO is full keeps it from overflowing.
                if (!cmdEmpty && !chkBusy[0] && !doneFull) begin
                    dispatch  = 1'b1;
                    stateNext = LD_S;
                end
            end
            LD_S: begin
                loadS     = 1'b1;
                cpyData   = {1'b0, curCmd.src};
                stateNext = LD_D;
            end
            LD_D: begin
                loadD     = 1'b1;
                cpyData   = {1'b0, curCmd.dst};
                stateNext = LD_L;
            end
            LD_L: begin
                loadL     = 1'b1;
                cpyData   = {1'b0, curCmd.len};
                stateNext = WAIT_START;
            end
            WAIT_START: begin
                if (chkBusy[0])       stateNext = WAIT_DONE;
                else if (startWaited) stateNext = CAPTURE;
            end
            WAIT_DONE: begin
                if (!chkBusy[0]) stateNext = CAPTURE;
            end
            CAPTURE: begin
                capture   = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (!reset) begin
            loadS   = 1'b0;
            loadD   = 1'b0;
            loadL   = 1'b0;
            cpyData = '0;
        end
    end

    always_comb begin
        doneRec = '0;
        doneRec[DONE_SEQ_LSB +: 8]  = seq;
        doneRec[DONE_CKS_LSB +: 16] = ~chkBusy[16:1];
    end

    sync_fifo #(
        .WIDTH (DONE_REC_WIDTH),
        .DEPTH (DONE_DEPTH)
    ) doneFifo (
        .clock  (clock),
        .reset  (reset),
        .push   (capture),
        .wrData (doneRec),
        .pop    (doneRead),
        .rdData (doneHead),
        .count  (unusedDoneCount),
        .full   (doneFull),
        .empty  (doneEmpty)
    );

    assign doneValid = !doneEmpty;

    always_comb begin
        doneData = '0;
        doneData[DONE_REC_WIDTH-1:0] = doneHead;
    end

    assign busy = !cmdEmpty || (state != IDLE);

endmodule

// File: tb/tb_copy_cmd_queue.sv
// Directed bench for copy_cmd_queue with a behavioural copier model.
module tb_copy_cmd_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] wq = '0;
    logic        cmdWrS = 1'b0;
    logic        cmdWrD = 1'b0;
    logic        cmdWrL = 1'b0;
    logic [4:0]  cmdCount;
    logic        cmdFull;
    logic        loadS;
    logic        loadD;
    logic        loadL;
    logic [31:0] cpyData;
    logic [16:0] chkBusy;
    logic        doneValid;
    logic [31:0] doneData;
    logic        doneRead = 1'b0;
    logic        busy;
    logic        lostCmd;

    int nPass  = 0;
    int nFail  = 0;
    int nTotal = 0;

    always #5 clock = ~clock;

    copy_cmd_queue #(
        .CMD_DEPTH  (4),
        .DONE_DEPTH (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .wq        (wq),
        .cmdWrS    (cmdWrS),
        .cmdWrD    (cmdWrD),
        .cmdWrL    (cmdWrL),
        .cmdCount  (cmdCount),
        .cmdFull   (cmdFull),
        .loadS     (loadS),
        .loadD     (loadD),
        .loadL     (loadL),
        .cpyData   (cpyData),
        .chkBusy   (chkBusy),
        .doneValid (doneValid),
        .doneData  (doneData),
        .doneRead  (doneRead),
        .busy      (busy),
        .lostCmd   (lostCmd)
    );

    // Copier model: busy for busyLen cycles after a nonzero L, then shows its checksum.
    logic        holdBusy = 1'b0;
    logic        useFixed = 1'b1;
    logic [15:0] fixedCks = 16'h1234;
    int          busyLen  = 20;
    logic        copBusy  = 1'b0;
    logic [15:0] chkInv   = 16'hFFFF;
    logic [15:0] pendCks  = '0;
    int          copCnt   = 0;
    logic [31:0] sQ[$];
    logic [31:0] dQ[$];
    logic [31:0] lQ[$];

    always @(posedge clock) begin
        if (!reset) begin
            copBusy <= 1'b0;
            chkInv  <= 16'hFFFF;
            copCnt  <= 0;
        end else if (loadL) begin
            if (cpyData == 32'd0) begin
                chkInv <= 16'hFFFF;
            end else begin
                copBusy <= 1'b1;
                copCnt  <= busyLen;
                pendCks <= useFixed ? fixedCks : {8'hC5, cpyData[7:0]};
            end
        end else if (copBusy) begin
            if (copCnt == 1) begin
                copBusy <= 1'b0;
                chkInv  <= ~pendCks;
            end
            copCnt <= copCnt - 1;
        end
    end

    assign chkBusy = {chkInv, copBusy | holdBusy};

    always @(posedge clock) begin
        if (loadS) sQ.push_back(cpyData);
        if (loadD) dQ.push_back(cpyData);
        if (loadL) lQ.push_back(cpyData);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTotal++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pushCmd(input logic [30:0] s, input logic [30:0] d, input logic [30:0] l);
        wq = {1'b1, s}; cmdWrS = 1'b1; step(1); cmdWrS = 1'b0;
        wq = {1'b1, d}; cmdWrD = 1'b1; step(1); cmdWrD = 1'b0;
        wq = {1'b1, l}; cmdWrL = 1'b1; step(1); cmdWrL = 1'b0;
        wq = '0;
    endtask

    task automatic readDone();
        doneRead = 1'b1; step(1); doneRead = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        for (int k = 0; k < budget && busy; k++) step(1);
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic waitDone(input string tag, input int budget);
        for (int k = 0; k < budget && !doneValid; k++) step(1);
        if (!doneValid) check(tag, {31'd0, doneValid}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rec;
        int          nL;

        step(3);
        check("rst_cmdCount", {27'd0, cmdCount}, 32'd0);
        check("rst_doneValid", {31'd0, doneValid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_loads", {29'd0, loadS, loadD, loadL}, 32'd0);
        check("rst_cpyData", cpyData, 32'd0);
        check("rst_lostCmd", {31'd0, lostCmd}, 32'd0);
        reset = 1'b1;
        step(1);

        // Single command: exact load timing and 20-cycle copier.
        pushCmd(31'h100, 31'h208, 31'd5);
        check("t1_noLoadS", {31'd0, loadS}, 32'd0);
        check("t1_count", {27'd0, cmdCount}, 32'd1);
        step(1);
        check("t2_loadS", {31'd0, loadS}, 32'd1);
        check("t2_dataS", cpyData, 32'h100);
        check("t2_count", {27'd0, cmdCount}, 32'd0);
        step(1);
        check("t3_loadD", {31'd0, loadD}, 32'd1);
        check("t3_dataD", cpyData, 32'h208);
        step(1);
        check("t4_loadL", {31'd0, loadL}, 32'd1);
        check("t4_dataL", cpyData, 32'd5);
        step(22);
        check("c22_noDone", {31'd0, doneValid}, 32'd0);
        step(1);
        check("c23_done", {31'd0, doneValid}, 32'd1);
        check("c23_data", doneData, 32'h0000_1234);
        readDone();
        check("read_clears", {31'd0, doneValid}, 32'd0);

        // Overfill the queue while the copier is held busy.
        sQ.delete(); dQ.delete(); lQ.delete();
        useFixed = 1'b0;
        busyLen  = 3;
        holdBusy = 1'b1;
        for (int i = 0; i < 5; i++)
            pushCmd(31'(16 * (i + 1)), 31'(32'h1000 + i), 31'(i + 1));
        step(2);
        check("full_count", {27'd0, cmdCount}, 32'd4);
        check("full_flag", {31'd0, cmdFull}, 32'd1);
        check("full_lost", {31'd0, lostCmd}, 32'd1);
        check("full_busy", {31'd0, busy}, 32'd1);
        check("full_noLoad", 32'(sQ.size()), 32'd0);
        holdBusy = 1'b0;
        waitIdle("drain_idle", 300);
        check("drain_loads", 32'(sQ.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("order_s%0d", i), sQ[i], 32'(16 * (i + 1)));
            check($sformatf("order_d%0d", i), dQ[i], 32'(32'h1000 + i));
            check($sformatf("order_l%0d", i), lQ[i], 32'(i + 1));
        end

        // Completion FIFO full: next command must wait for a read.
        pushCmd(31'h60, 31'h6060, 31'd6);
        step(10);
        check("gate_noLoadS", 32'(sQ.size()), 32'd4);
        check("gate_count", {27'd0, cmdCount}, 32'd1);
        check("gate_head", doneData, 32'h0001_C501);
        readDone();
        waitIdle("gate_idle", 100);
        check("gate_loadS", 32'(sQ.size()), 32'd5);
        check("gate_src", sQ[4], 32'h60);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rec_valid%0d", i), {31'd0, doneValid}, 32'd1);
            check($sformatf("rec_data%0d", i), doneData,
                  {8'h00, 8'(i + 2), 8'hC5, (i == 3) ? 8'd6 : 8'(i + 2)});
            readDone();
        end
        check("rec_empty", {31'd0, doneValid}, 32'd0);

        // Zero-length command never raises busy.
        pushCmd(31'h7, 31'h8, 31'd0);
        step(3);
        check("z_loadL", {31'd0, loadL}, 32'd1);
        check("z_dataL", cpyData, 32'd0);
        step(3);
        check("z_noDone", {31'd0, doneValid}, 32'd0);
        step(1);
        check("z_done", {31'd0, doneValid}, 32'd1);
        check("z_data", doneData, 32'h0006_0000);
        readDone();

        // Sequence number wraps after 256 completions.
        for (int i = 7; i <= 256; i++) begin
            pushCmd(31'd0, 31'd0, 31'd0);
            waitDone("wrap_timeout", 20);
            rec = doneData;
            readDone();
            if (i == 255) check("wrap_seqFF", rec, 32'h00FF_0000);
            if (i == 256) check("wrap_seq00", rec, 32'h0000_0000);
        end

        // Reset while in LD_D abandons the command.
        pushCmd(31'd0, 31'd0, 31'd0);
        waitDone("pre_rst_timeout", 20);
        check("pre_rst_valid", {31'd0, doneValid}, 32'd1);
        pushCmd(31'h11, 31'h22, 31'd3);
        step(1);
        check("rst_mid_loadS", cpyData, 32'h11);
        step(1);
        check("rst_mid_loadD", {31'd0, loadD}, 32'd1);
        nL = lQ.size();
        reset = 1'b0;
        step(1);
        check("rst_mid_noLoadL", {31'd0, loadL}, 32'd0);
        check("rst_mid_count", {27'd0, cmdCount}, 32'd0);
        check("rst_mid_done", {31'd0, doneValid}, 32'd0);
        check("rst_mid_lost", {31'd0, lostCmd}, 32'd0);
        reset = 1'b1;
        step(6);
        check("rst_mid_lQ", 32'(lQ.size()), 32'(nL));
        check("rst_mid_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/copy_cmd_queue.md
COPY_CMD_QUEUE -- requirements
Module: copy_cmd_queue

Interface
REQ-001 Parameter CMD_DEPTH, default 4, number of queued copy commands (power of 2, 2..16).
REQ-002 Parameter DONE_DEPTH, default 4, number of completion records held (power of 2, 2..16).
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low: reset==0 at a rising clock edge resets the block.
REQ-005 wq  in  32  RISC write-queue data; bits [30:0] carry an address or length.
REQ-006 cmdWrS  in  1  strobe: stage wq[30:0] as source word address.
REQ-007 cmdWrD  in  1  strobe: stage wq[30:0] as destination word address.
REQ-008 cmdWrL  in  1  strobe: stage wq[30:0] as length and push the {S,D,L} triple.
REQ-009 cmdCount  out  5  number of queued, not-yet-dispatched commands.
REQ-010 cmdFull  out  1  cmdCount == CMD_DEPTH.
REQ-011 loadS, loadD, loadL  out  1 each  one-cycle load pulses to the copier.
REQ-012 cpyData  out  32  value for the copier, {1'b0, field}, valid during the matching load pulse.
REQ-013 chkBusy  in  17  copier status: bit0 = busy; [16:1] = inverted 16-bit checksum.
REQ-014 doneValid  out  1  completion FIFO non-empty.
REQ-015 doneData  out  32  head record {8'b0, seq[7:0], checksum[15:0]}.
REQ-016 doneRead  in  1  pop the completion head; ignored when doneValid==0.
REQ-017 busy  out  1  queue non-empty or the FSM is not in IDLE.

Function
REQ-018 Each cmdWrS/cmdWrD updates its staging register in the same cycle; there is no ordering requirement.
REQ-019 cmdWrL with cmdFull==0 pushes {stageS, stageD, wq[30:0]}; the new length is used, and cmdCount increments the next cycle.
REQ-020 cmdWrL with cmdFull==1 is dropped, and sticky bit lostCmd (doneData is unaffected) is set until reset.
REQ-021 A simultaneous push and dispatch-pop leaves cmdCount unchanged; FIFO pointers wrap modulo CMD_DEPTH.
REQ-022 FSM states: IDLE, LD_S, LD_D, LD_L, WAIT_START, WAIT_DONE, CAPTURE.
REQ-023 IDLE -> LD_S requires all three: cmdCount!=0, chkBusy[0]==0, and doneCount < DONE_DEPTH. The queue head is popped in that cycle.
REQ-024 LD_S, LD_D and LD_L each assert exactly one load pulse with the matching cpyData, then advance one state per cycle. The order is always S, D, L, with L last because the copier starts on L.
REQ-025 WAIT_START waits at most 2 cycles for chkBusy[0]==1, then goes to WAIT_DONE. If chkBusy[0] is not seen high (L==0), it goes directly to CAPTURE.
REQ-026 WAIT_DONE -> CAPTURE on the first cycle with chkBusy[0]==0. There is no timeout.
REQ-027 CAPTURE pushes {seq, ~chkBusy[16:1]} into the completion FIFO, increments seq by 1 (8-bit, wraps 255 -> 0), and returns to IDLE.
REQ-028 The dispatch gate in REQ-023 guarantees the completion FIFO never overflows. A simultaneous CAPTURE push and doneRead pop leaves doneCount unchanged.
REQ-029 Latency from push into an empty queue with an idle copier to loadS is 2 cycles; loadS -> loadD -> loadL follow on consecutive cycles.
REQ-030 doneData is registered FIFO-head data; it is valid whenever doneValid==1.

Reset
REQ-031 While reset==0: FIFOs are emptied, cmdCount=0, doneValid=0, FSM=IDLE, load pulses=0, cpyData=0, seq=0, lostCmd=0, and staging registers=0.
REQ-032 Reset mid-dispatch abandons the command with no further load pulses. The copier is reset by the same net.

Structure
REQ-033 FSM state encodings and the doneData field offsets live in the shared copier package.
REQ-034 A single parameterised sub-module sync_fifo (width, depth, count, full/empty) is instantiated twice: 93-bit commands and 24-bit completions.

Verification
REQ-035 Push S=0x100, D=0x208, L=5 with the copier idle -> loadS/loadD/loadL on cycles t+2/t+3/t+4 with cpyData 0x100/0x208/5.
REQ-036 Copier model holds busy 20 cycles, then checksum 0x1234 -> doneValid, doneData=0x00001234; doneRead clears doneValid.
REQ-037 Push 5 commands with CMD_DEPTH=4 while the copier is busy -> cmdFull=1, 5th command dropped, lostCmd=1, 4 dispatched in order.
REQ-038 L=0 command -> no busy seen; CAPTURE after 2 WAIT_START cycles; record checksum 0x0000 (chkBusy[16:1]=0xFFFF).
REQ-039 DONE_DEPTH records unread -> no further loadS until one doneRead; seq wraps 0xFF -> 0x00 after 256 commands.
REQ-040 reset=0 asserted in LD_D -> no loadL, cmdCount=0, doneValid=0 on the next cycle.
